// File: rtl/seq_pkg.sv
// Shared types for the seq_gen / seq_chk family: FSM state encoding and default run-counter width.
package seq_pkg;

  localparam int RUN_W_DEF = 8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ONES = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_chk_if.sv
// Serial pattern link between a sequence generator (master) and the checker (slave).
interface seq_chk_if
  import seq_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF
);

  logic             i_seq;
  logic [RUN_W-1:0] o_run_len;
  logic             o_run_vld;
  logic             o_err;
  logic             o_lock;

  modport master (
    output i_seq,
    input  o_run_len, o_run_vld, o_err, o_lock
  );

  modport slave (
    input  i_seq,
    output o_run_len, o_run_vld, o_err, o_lock
  );

endinterface

// File: rtl/seq_chk_stat.sv
// Saturating 16-bit counters of completed runs and error pulses (built only with SEQ_CHK_STAT_EN).
module seq_chk_stat (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_run_vld,
  input  logic        i_err,
  output logic [15:0] o_run_cnt,
  output logic [15:0] o_err_cnt
);

  logic [15:0] run_cnt_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      run_cnt_reg <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else begin
      if (i_run_vld && (run_cnt_reg != 16'hFFFF)) run_cnt_reg <= run_cnt_reg + 16'd1;
      if (i_err && (err_cnt_reg != 16'hFFFF))     err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign o_run_cnt = run_cnt_reg;
  assign o_err_cnt = err_cnt_reg;

endmodule

// File: rtl/seq_chk.sv
// Checker for the growing-run pattern (runs N, N+1, ... of ones split by single zeros).
// Optional statistics outputs are enabled by defining SEQ_CHK_STAT_EN.
module seq_chk
  import seq_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  seq_chk_if.slave    bus
`ifdef SEQ_CHK_STAT_EN
  ,
  output logic [15:0] o_run_cnt,
  output logic [15:0] o_err_cnt
`endif
);

  localparam logic [RUN_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] CNT_ONE = RUN_W'(1);

  seq_state_e       state_reg, state_next;
  logic [RUN_W-1:0] cnt_reg, cnt_next;
  logic [RUN_W-1:0] exp_len_reg, exp_len_next;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic             have_ref_reg, have_ref_next;
  logic             run_vld_reg, run_vld_next;
  logic             err_reg, err_next;
  logic             lock_reg, lock_next;
  logic [RUN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_reg + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_reg    <= HUNT;
      cnt_reg      <= '0;
      exp_len_reg  <= '0;
      run_len_reg  <= '0;
      have_ref_reg <= 1'b0;
      run_vld_reg  <= 1'b0;
      err_reg      <= 1'b0;
      lock_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      exp_len_reg  <= exp_len_next;
      run_len_reg  <= run_len_next;
      have_ref_reg <= have_ref_next;
      run_vld_reg  <= run_vld_next;
      err_reg      <= err_next;
      lock_reg     <= lock_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    exp_len_next  = exp_len_reg;
    run_len_next  = run_len_reg;
    have_ref_next = have_ref_reg;
    run_vld_next  = 1'b0;
    err_next      = 1'b0;
    lock_next     = lock_reg;
    case (state_reg)
      // A run already in progress is never measured; wait for a zero first.
      HUNT: begin
        if (!bus.i_seq) state_next = GAP;
      end
      GAP: begin
        if (bus.i_seq) begin
          state_next = ONES;
          cnt_next   = CNT_ONE;
        end else if (have_ref_reg) begin
          err_next      = 1'b1;
          have_ref_next = 1'b0;
          lock_next     = 1'b0;
        end
      end
      ONES: begin
        if (bus.i_seq) begin
          if (cnt_reg == CNT_MAX) begin
            err_next      = 1'b1;
            have_ref_next = 1'b0;
            lock_next     = 1'b0;
            cnt_next      = '0;
            state_next    = HUNT;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          state_next   = GAP;
          run_len_next = cnt_reg;
          run_vld_next = 1'b1;
          if (have_ref_reg) begin
            if (cnt_reg == exp_len_reg) begin
              lock_next = 1'b1;
            end else begin
              err_next  = 1'b1;
              lock_next = 1'b0;
            end
          end
          // A wrapped expectation of 0 would be unreachable, so it becomes 1.
          exp_len_next  = (cnt_inc == '0) ? CNT_ONE : cnt_inc;
          have_ref_next = 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign bus.o_run_len = run_len_reg;
  assign bus.o_run_vld = run_vld_reg;
  assign bus.o_err     = err_reg;
  assign bus.o_lock    = lock_reg;

`ifdef SEQ_CHK_STAT_EN
  seq_chk_stat u_stat (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_run_vld (run_vld_reg),
    .i_err     (err_reg),
    .o_run_cnt (o_run_cnt),
    .o_err_cnt (o_err_cnt)
  );
`endif

endmodule
